// File: rtl/kpn_bcast_fifo.sv
// kpn_bcast_fifo: single-producer, multi-reader broadcast FIFO.
// Every accepted token is delivered once to each of READERS consumers, in
// write order, with first-word-fall-through heads. One shared write pointer,
// one read pointer per reader; occupancy of the slowest reader sets full/level.
// Optional statistics (hwm, drops) are built when KPN_FIFO_STATS_EN is defined.

// Per-reader port: read pointer, occupancy and empty flag for one consumer.
module kpn_bcast_rdport #(
  parameter int PW = 4,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd,
  input  logic [PW-1:0] wptr,
  output logic [AW-1:0] raddr,
  output logic [PW-1:0] occ,
  output logic          empty
);
  logic [PW-1:0] rptr;

  // Pointers carry a wrap bit, so plain modulo subtraction gives occupancy.
  assign occ   = wptr - rptr;
  assign empty = (occ == '0);
  assign raddr = rptr[AW-1:0];

  // Pop only when this reader has a token; reads while empty are ignored.
  always_ff @(posedge clk) begin
    if (rst)              rptr <= '0;
    else if (rd && !empty) rptr <= rptr + PW'(1);
  end
endmodule

module kpn_bcast_fifo #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 8,
  parameter int READERS = 2,
  localparam int AW     = $clog2(DEPTH),
  localparam int PW     = AW + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr,
  input  logic [WIDTH-1:0]           entry_1,
  output logic                       full,
  input  logic [READERS-1:0]         rd,
  output logic [READERS*WIDTH-1:0]   output_1,
  output logic [READERS-1:0]         empty,
  output logic [PW-1:0]              level,
`ifdef KPN_FIFO_STATS_EN
  output logic [PW-1:0]              hwm,
  output logic [15:0]                drops,
`endif
  output logic                       overflow
);
  logic [WIDTH-1:0]              mem [DEPTH];
  logic [PW-1:0]                 wptr;
  logic [READERS-1:0][AW-1:0]    raddr;
  logic [READERS-1:0][PW-1:0]    occ;
  logic                          wr_ok;
  logic                          wr_drop;

  // One read port per consumer; heads are read asynchronously (FWFT).
  for (genvar g = 0; g < READERS; g++) begin : g_rd
    kpn_bcast_rdport #(.PW(PW), .AW(AW)) u_rdport (
      .clk   (clk),
      .rst   (rst),
      .rd    (rd[g]),
      .wptr  (wptr),
      .raddr (raddr[g]),
      .occ   (occ[g]),
      .empty (empty[g])
    );
    assign output_1[g*WIDTH +: WIDTH] = mem[raddr[g]];
  end

  // Level is the occupancy of the slowest reader.
  always_comb begin
    level = '0;
    for (int i = 0; i < READERS; i++)
      if (occ[i] > level) level = occ[i];
  end

  assign full    = (level == PW'(DEPTH));
  assign wr_ok   = wr && !full;
  assign wr_drop = wr && full;

  // Write pointer and overflow pulse; a write is judged on pre-edge full.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + PW'(1);
      overflow <= wr_drop;
    end
  end

  // Storage is not reset; contents are only observed while a reader is non-empty.
  always_ff @(posedge clk) begin
    if (wr_ok && !rst) mem[wptr[AW-1:0]] <= entry_1;
  end

`ifdef KPN_FIFO_STATS_EN
  logic [PW-1:0] hwm_q;

  // High-water mark includes the current level so it never lags a peak.
  assign hwm = (level > hwm_q) ? level : hwm_q;

  // Track peak level and count rejected writes, saturating the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      hwm_q <= '0;
      drops <= '0;
    end else begin
      if (level > hwm_q) hwm_q <= level;
      if (wr_drop && drops != 16'hFFFF) drops <= drops + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_kpn_bcast_fifo.sv
// Randomized + directed bench for kpn_bcast_fifo at default parameters.
// Reference model: a token history list plus per-reader consumed counts.
module tb_kpn_bcast_fifo;
  localparam int WIDTH = 16, DEPTH = 8, READERS = 2, PW = 4;

  logic                     clk, rst, wr, full, overflow;
  logic [WIDTH-1:0]         entry_1;
  logic [READERS-1:0]       rd, empty;
  logic [READERS*WIDTH-1:0] output_1;
  logic [PW-1:0]            level;
`ifdef KPN_FIFO_STATS_EN
  logic [PW-1:0]            hwm;
  logic [15:0]              drops;
`endif

  kpn_bcast_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .READERS(READERS)) dut (
    .clk(clk), .rst(rst), .wr(wr), .entry_1(entry_1), .full(full), .rd(rd),
    .output_1(output_1), .empty(empty), .level(level),
`ifdef KPN_FIFO_STATS_EN
    .hwm(hwm), .drops(drops),
`endif
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errs = 0;

  // Model state
  logic [WIDTH-1:0] hist[$];
  int wcnt;
  int rcnt [READERS];
  bit ov_m;
  int hwm_m, drops_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_level();
    int mx = 0;
    for (int i = 0; i < READERS; i++)
      if (wcnt - rcnt[i] > mx) mx = wcnt - rcnt[i];
    return mx;
  endfunction

  task automatic verify();
    int lv;
    lv = model_level();
    for (int i = 0; i < READERS; i++) begin
      chk($sformatf("empty%0d", i), 32'(empty[i]), 32'(wcnt == rcnt[i]));
      if (wcnt != rcnt[i])
        chk($sformatf("head%0d", i), 32'(output_1[i*WIDTH +: WIDTH]), 32'(hist[rcnt[i]]));
    end
    chk("level", 32'(level), 32'(lv));
    chk("full", 32'(full), 32'(lv == DEPTH));
    chk("overflow", 32'(overflow), 32'(ov_m));
`ifdef KPN_FIFO_STATS_EN
    chk("hwm", 32'(hwm), 32'(hwm_m));
    chk("drops", 32'(drops), 32'(drops_m));
`endif
  endtask

  // Apply one cycle of stimulus, advance the model on spec rules, then compare.
  task automatic step(input bit r, input bit w, input logic [WIDTH-1:0] d,
                      input logic [READERS-1:0] rr);
    int occ [READERS];
    bit full_pre;
    rst = r; wr = w; entry_1 = d; rd = rr;
    for (int i = 0; i < READERS; i++) occ[i] = wcnt - rcnt[i];
    full_pre = (model_level() == DEPTH);
    @(posedge clk); #1;
    if (r) begin
      hist.delete(); wcnt = 0;
      for (int i = 0; i < READERS; i++) rcnt[i] = 0;
      ov_m = 0; hwm_m = 0; drops_m = 0;
    end else begin
      ov_m = w && full_pre;
      if (w && full_pre && drops_m != 16'hFFFF) drops_m++;
      if (w && !full_pre) begin hist.push_back(d); wcnt++; end
      for (int i = 0; i < READERS; i++) if (rr[i] && occ[i] != 0) rcnt[i]++;
    end
    if (model_level() > hwm_m) hwm_m = model_level();
    verify();
  endtask

  initial begin
    int p0, p1;
    rst = 1'b0; wr = 1'b0; entry_1 = '0; rd = '0;
    wcnt = 0; rcnt = '{default: 0}; ov_m = 0; hwm_m = 0; drops_m = 0;

    // Reset state
    step(1, 0, 0, 2'b00);
    chk("rst_empty", 32'(empty), 32'h3);
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_full", 32'(full), 32'h0);

    // Basic broadcast 1,2,3
    step(0, 1, 16'h0001, 2'b00);
    step(0, 1, 16'h0002, 2'b00);
    step(0, 1, 16'h0003, 2'b00);
    for (int k = 1; k <= 3; k++) begin
      chk("bc_head0", 32'(output_1[15:0]), 32'(k));
      chk("bc_head1", 32'(output_1[31:16]), 32'(k));
      step(0, 0, 0, 2'b11);
    end
    chk("bc_empty", 32'(empty), 32'h3);

    // Stalled reader 1: fill, then overflow
    step(1, 0, 0, 2'b00);
    for (int k = 0; k < 8; k++) step(0, 1, 16'(16'h100 + k), 2'b01);
    chk("stall_full", 32'(full), 32'h1);
    chk("stall_level", 32'(level), 32'h8);
    step(0, 1, 16'hDEAD, 2'b00);
    chk("stall_ovf", 32'(overflow), 32'h1);
`ifdef KPN_FIFO_STATS_EN
    chk("stall_drops", 32'(drops), 32'h1);
`endif
    // Full plus read on the slow reader: write still rejected
    step(0, 1, 16'hBEEF, 2'b10);
    chk("fullrd_level", 32'(level), 32'h7);
    chk("fullrd_ovf", 32'(overflow), 32'h1);
    chk("fullrd_head1", 32'(output_1[31:16]), 32'h101);
    step(0, 0, 0, 2'b00);
    chk("ovf_pulse_end", 32'(overflow), 32'h0);

    // Empty plus write: pops ignored
    step(1, 0, 0, 2'b00);
    step(0, 1, 16'h00AA, 2'b11);
    chk("ew_head0", 32'(output_1[15:0]), 32'h00AA);
    chk("ew_head1", 32'(output_1[31:16]), 32'h00AA);
    chk("ew_level", 32'(level), 32'h1);

    // Wrap-around: 20 write+pop-all cycles
    step(1, 0, 0, 2'b00);
    for (int k = 0; k < 20; k++) begin
      step(0, 1, 16'(16'h200 + k), 2'b11);
      chk("wrap_full", 32'(full), 32'h0);
      chk("wrap_empty", 32'(empty), 32'h0);
    end

    // Mid-operation reset at level 5
    step(1, 0, 0, 2'b00);
    for (int k = 0; k < 5; k++) step(0, 1, 16'(k), 2'b00);
    chk("mr_level5", 32'(level), 32'h5);
    step(1, 1, 16'h5555, 2'b11);
    chk("mr_empty", 32'(empty), 32'h3);
    chk("mr_level", 32'(level), 32'h0);
    chk("mr_full", 32'(full), 32'h0);
`ifdef KPN_FIFO_STATS_EN
    chk("mr_hwm", 32'(hwm), 32'h0);
`endif

    // Randomized traffic with shifting reader speeds
    p0 = 50; p1 = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 250 == 0) begin
        p0 = $urandom_range(0, 100);
        p1 = $urandom_range(0, 100);
      end
      step(($urandom_range(0, 399) == 0), ($urandom_range(0, 99) < 60),
           16'($urandom), {($urandom_range(0, 99) < p1), ($urandom_range(0, 99) < p0)});
    end

    rst = 1'b0; wr = 1'b0; rd = '0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, errs);
    $finish;
  end
endmodule
